// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline hazard controller.
package pipe_ctrl_pkg;

   localparam logic [1:0] PCSEL_SEQ = 2'd0;
   localparam logic [1:0] PCSEL_BR  = 2'd1;
   localparam logic [1:0] PCSEL_JR  = 2'd2;
   localparam logic [1:0] PCSEL_J   = 2'd3;

   localparam logic [4:0] REG_ZERO  = 5'd0;

   typedef enum logic {
      S_RUN = 1'b0,
      S_MD  = 1'b1
   } state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bus between the ID/EX/IF pipeline side (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic [1:0]       id_pcsrc;
   logic             ex_wreg;
   logic             ex_m2reg;
   logic [4:0]       ex_rd;
   logic             ex_md_start;
   logic             imem_ready;
   logic             wpcir;
   logic [1:0]       pcsel;
   logic             ifid_flush;
   logic             idex_bubble;
   logic             md_busy;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, id_pcsrc,
             ex_wreg, ex_m2reg, ex_rd, ex_md_start, imem_ready,
      input  wpcir, pcsel, ifid_flush, idex_bubble, md_busy, stall_count
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, id_pcsrc,
             ex_wreg, ex_m2reg, ex_rd, ex_md_start, imem_ready,
      output wpcir, pcsel, ifid_flush, idex_bubble, md_busy, stall_count
   );
endinterface

// File: rtl/pipe_hazard_ctrl_stall_counter.sv
// Saturating event counter with synchronous active-high reset.
module pipe_stall_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             en_i,
   output logic [CNT_W-1:0] count_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Sequences PC hold, next-PC select, IF/ID flush and ID/EX bubble for
// load-use, mul/div occupancy, imem wait states and control transfers.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MD_LAT     = 4,
   parameter int unsigned DELAY_SLOT = 1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic               clock,
   input  logic               reset,
   pipe_hazard_ctrl_if.slave  bus
);

   localparam int unsigned MDC_W = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;

   state_e             state_q, state_d;
   logic [MDC_W-1:0]   md_cnt_q, md_cnt_d;
   logic               lu, iw;

   assign lu = bus.ex_m2reg & bus.ex_wreg & (bus.ex_rd != REG_ZERO) &
               ((bus.id_use_rs & (bus.id_rs == bus.ex_rd)) |
                (bus.id_use_rt & (bus.id_rt == bus.ex_rd)));
   assign iw = ~bus.imem_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_RUN;
         md_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
      end
   end

   // The counter holds remaining S_MD cycles minus one; exit happens on zero.
   always_comb begin
      state_d  = state_q;
      md_cnt_d = md_cnt_q;
      case (state_q)
         S_RUN: begin
            if (bus.ex_md_start) begin
               state_d  = S_MD;
               md_cnt_d = MDC_W'(MD_LAT - 2);
            end
         end
         S_MD: begin
            if (md_cnt_q == '0) state_d = S_RUN;
            else                md_cnt_d = md_cnt_q - MDC_W'(1);
         end
         default: state_d = S_RUN;
      endcase
   end

   always_comb begin
      bus.wpcir       = 1'b0;
      bus.pcsel       = PCSEL_SEQ;
      bus.ifid_flush  = 1'b0;
      bus.idex_bubble = 1'b0;
      bus.md_busy     = (state_q == S_MD);
      if (reset) begin
         bus.wpcir = 1'b1;
      end else if (state_q == S_MD) begin
         bus.wpcir       = 1'b1;
         bus.idex_bubble = 1'b1;
      end else if (lu) begin
         bus.wpcir       = 1'b1;
         bus.idex_bubble = 1'b1;
      end else if (iw) begin
         bus.wpcir = 1'b1;
      end else begin
         bus.pcsel      = bus.id_pcsrc;
         bus.ifid_flush = (DELAY_SLOT == 0) && (bus.id_pcsrc != PCSEL_SEQ);
      end
   end

   pipe_stall_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk_i   (clock),
      .rst_i   (reset),
      .en_i    (bus.wpcir),
      .count_o (bus.stall_count)
   );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: instance A (DELAY_SLOT=0, 16-bit counter) and instance B
// (DELAY_SLOT=1, 4-bit counter) share one stimulus stream.
module tb_pipe_hazard_ctrl;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic [4:0] id_rs, id_rt, ex_rd;
   logic       id_use_rs, id_use_rt, ex_wreg, ex_m2reg, ex_md_start, imem_ready;
   logic [1:0] id_pcsrc;

   int checks   = 0;
   int failures = 0;
   int exp_a    = 0;
   int exp_b    = 0;

   pipe_hazard_ctrl_if #(.CNT_W(16)) bus_a ();
   pipe_hazard_ctrl_if #(.CNT_W(4))  bus_b ();

   assign bus_a.id_rs = id_rs;             assign bus_b.id_rs = id_rs;
   assign bus_a.id_rt = id_rt;             assign bus_b.id_rt = id_rt;
   assign bus_a.id_use_rs = id_use_rs;     assign bus_b.id_use_rs = id_use_rs;
   assign bus_a.id_use_rt = id_use_rt;     assign bus_b.id_use_rt = id_use_rt;
   assign bus_a.id_pcsrc = id_pcsrc;       assign bus_b.id_pcsrc = id_pcsrc;
   assign bus_a.ex_wreg = ex_wreg;         assign bus_b.ex_wreg = ex_wreg;
   assign bus_a.ex_m2reg = ex_m2reg;       assign bus_b.ex_m2reg = ex_m2reg;
   assign bus_a.ex_rd = ex_rd;             assign bus_b.ex_rd = ex_rd;
   assign bus_a.ex_md_start = ex_md_start; assign bus_b.ex_md_start = ex_md_start;
   assign bus_a.imem_ready = imem_ready;   assign bus_b.imem_ready = imem_ready;

   pipe_hazard_ctrl #(.MD_LAT(4), .DELAY_SLOT(0), .CNT_W(16)) dut_a (
      .clock (clock), .reset (reset), .bus (bus_a.slave)
   );
   pipe_hazard_ctrl #(.MD_LAT(4), .DELAY_SLOT(1), .CNT_W(4)) dut_b (
      .clock (clock), .reset (reset), .bus (bus_b.slave)
   );

   task automatic idle();
      id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
      id_use_rs = 1'b0; id_use_rt = 1'b0; ex_wreg = 1'b0; ex_m2reg = 1'b0;
      ex_md_start = 1'b0; imem_ready = 1'b1; id_pcsrc = 2'd0;
   endtask

   // Advance one edge, then settle inputs/outputs 1 time unit after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      id_pcsrc = 2'd3;
      tick();
      tick();
      #3;
      checks++;
      if (bus_a.wpcir !== 1'b1) begin failures++; $display("FAIL rst_wpcir got=%0b exp=1", bus_a.wpcir); end
      checks++;
      if (bus_a.pcsel !== 2'd0) begin failures++; $display("FAIL rst_pcsel got=%0d exp=0", bus_a.pcsel); end
      tick();
      reset = 1'b0;
      id_pcsrc = 2'd0;
      #3;
      checks++;
      if (bus_a.wpcir !== 1'b0) begin failures++; $display("FAIL post_rst_wpcir got=%0b exp=0", bus_a.wpcir); end
      checks++;
      if (bus_a.md_busy !== 1'b0) begin failures++; $display("FAIL post_rst_md_busy got=%0b exp=0", bus_a.md_busy); end
      checks++;
      if (bus_a.stall_count !== 16'd0) begin failures++; $display("FAIL post_rst_count got=%0d exp=0", bus_a.stall_count); end
      checks++;
      if (bus_a.pcsel !== 2'd0) begin failures++; $display("FAIL post_rst_pcsel got=%0d exp=0", bus_a.pcsel); end
   endtask

   task automatic test_load_use();
      ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_rd = 5'd5; id_use_rt = 1'b1; id_rt = 5'd5;
      id_pcsrc = 2'd1;
      #3;
      checks++;
      if ({bus_a.wpcir, bus_a.idex_bubble, bus_a.pcsel, bus_a.ifid_flush} !== 5'b11_00_0) begin
         failures++;
         $display("FAIL lu_outputs got=%b exp=11000", {bus_a.wpcir, bus_a.idex_bubble, bus_a.pcsel, bus_a.ifid_flush});
      end
      tick();
      exp_a++; exp_b++;
      checks++;
      if (bus_a.stall_count !== 16'(exp_a)) begin failures++; $display("FAIL lu_count got=%0d exp=%0d", bus_a.stall_count, exp_a); end
      id_pcsrc = 2'd0;
      ex_rd = 5'd0; id_rt = 5'd0;
      #3;
      checks++;
      if ({bus_a.wpcir, bus_a.idex_bubble} !== 2'b00) begin failures++; $display("FAIL lu_r0_nostall got=%b exp=00", {bus_a.wpcir, bus_a.idex_bubble}); end
      tick();
      ex_rd = 5'd7; id_rs = 5'd7; id_use_rs = 1'b1; id_use_rt = 1'b0; ex_m2reg = 1'b0;
      #3;
      checks++;
      if (bus_a.wpcir !== 1'b0) begin failures++; $display("FAIL non_load_nostall got=%0b exp=0", bus_a.wpcir); end
      ex_m2reg = 1'b1; imem_ready = 1'b0;
      #1;
      checks++;
      if (bus_a.idex_bubble !== 1'b1) begin failures++; $display("FAIL lu_over_iw got=%0b exp=1", bus_a.idex_bubble); end
      tick();
      exp_a++; exp_b++;
      idle();
      #3;
      checks++;
      if (bus_a.stall_count !== 16'(exp_a)) begin failures++; $display("FAIL lu_rs_count got=%0d exp=%0d", bus_a.stall_count, exp_a); end
   endtask

   task automatic test_md();
      ex_md_start = 1'b1;
      #3;
      checks++;
      if ({bus_a.wpcir, bus_a.md_busy} !== 2'b00) begin failures++; $display("FAIL md_start_cycle got=%b exp=00", {bus_a.wpcir, bus_a.md_busy}); end
      tick();
      for (int i = 0; i < 3; i++) begin
         #3;
         checks++;
         if ({bus_a.md_busy, bus_a.wpcir, bus_a.idex_bubble} !== 3'b111) begin
            failures++;
            $display("FAIL md_busy_cycle%0d got=%b exp=111", i, {bus_a.md_busy, bus_a.wpcir, bus_a.idex_bubble});
         end
         tick();
      end
      exp_a += 3; exp_b += 3;
      ex_md_start = 1'b0;
      #3;
      checks++;
      if ({bus_a.md_busy, bus_a.wpcir} !== 2'b00) begin failures++; $display("FAIL md_exit got=%b exp=00", {bus_a.md_busy, bus_a.wpcir}); end
      checks++;
      if (bus_a.stall_count !== 16'(exp_a)) begin failures++; $display("FAIL md_count got=%0d exp=%0d", bus_a.stall_count, exp_a); end
   endtask

   task automatic test_imem_wait();
      imem_ready = 1'b0; id_pcsrc = 2'd3;
      for (int i = 0; i < 2; i++) begin
         #3;
         checks++;
         if ({bus_a.wpcir, bus_a.pcsel, bus_a.idex_bubble, bus_a.ifid_flush} !== 5'b1_00_0_0) begin
            failures++;
            $display("FAIL iw_cycle%0d got=%b exp=10000", i, {bus_a.wpcir, bus_a.pcsel, bus_a.idex_bubble, bus_a.ifid_flush});
         end
         tick();
      end
      exp_a += 2; exp_b += 2;
      imem_ready = 1'b1;
      #3;
      checks++;
      if ({bus_a.wpcir, bus_a.pcsel, bus_a.ifid_flush} !== 4'b0_11_1) begin
         failures++;
         $display("FAIL iw_release_a got=%b exp=0111", {bus_a.wpcir, bus_a.pcsel, bus_a.ifid_flush});
      end
      checks++;
      if ({bus_b.pcsel, bus_b.ifid_flush} !== 3'b11_0) begin failures++; $display("FAIL delay_slot_noflush got=%b exp=110", {bus_b.pcsel, bus_b.ifid_flush}); end
      tick();
      id_pcsrc = 2'd0;
      #3;
      checks++;
      if (bus_a.ifid_flush !== 1'b0) begin failures++; $display("FAIL flush_oneshot got=%0b exp=0", bus_a.ifid_flush); end
      checks++;
      if (bus_a.stall_count !== 16'(exp_a)) begin failures++; $display("FAIL iw_count got=%0d exp=%0d", bus_a.stall_count, exp_a); end
   endtask

   task automatic test_md_reset();
      ex_md_start = 1'b1;
      tick();
      ex_md_start = 1'b0;
      tick();
      reset = 1'b1;
      #3;
      checks++;
      if ({bus_a.md_busy, bus_a.wpcir} !== 2'b11) begin failures++; $display("FAIL md_rst_cycle got=%b exp=11", {bus_a.md_busy, bus_a.wpcir}); end
      tick();
      reset = 1'b0;
      exp_a = 0; exp_b = 0;
      #3;
      checks++;
      if ({bus_a.md_busy, bus_a.wpcir} !== 2'b00) begin failures++; $display("FAIL md_rst_exit got=%b exp=00", {bus_a.md_busy, bus_a.wpcir}); end
      checks++;
      if (bus_a.stall_count !== 16'd0) begin failures++; $display("FAIL md_rst_count got=%0d exp=0", bus_a.stall_count); end
      tick();
   endtask

   task automatic test_lu_md_same();
      ex_md_start = 1'b1; ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_rd = 5'd9;
      id_use_rs = 1'b1; id_rs = 5'd9;
      #3;
      checks++;
      if ({bus_a.wpcir, bus_a.idex_bubble, bus_a.md_busy} !== 3'b110) begin
         failures++;
         $display("FAIL lu_md_cycle got=%b exp=110", {bus_a.wpcir, bus_a.idex_bubble, bus_a.md_busy});
      end
      tick();
      idle();
      for (int i = 0; i < 3; i++) begin
         #3;
         checks++;
         if (bus_a.md_busy !== 1'b1) begin failures++; $display("FAIL lu_md_busy%0d got=%0b exp=1", i, bus_a.md_busy); end
         tick();
      end
      exp_a += 4; exp_b += 4;
      #3;
      checks++;
      if (bus_a.md_busy !== 1'b0) begin failures++; $display("FAIL lu_md_exit got=%0b exp=0", bus_a.md_busy); end
      checks++;
      if (bus_a.stall_count !== 16'(exp_a)) begin failures++; $display("FAIL lu_md_count got=%0d exp=%0d", bus_a.stall_count, exp_a); end
   endtask

   task automatic test_saturation();
      imem_ready = 1'b0;
      repeat (11) tick();
      exp_a += 11;
      exp_b = 15;
      #3;
      checks++;
      if (bus_b.stall_count !== 4'(exp_b)) begin failures++; $display("FAIL sat_reach got=%0d exp=%0d", bus_b.stall_count, exp_b); end
      repeat (3) tick();
      exp_a += 3;
      #3;
      checks++;
      if (bus_b.stall_count !== 4'd15) begin failures++; $display("FAIL sat_hold got=%0d exp=15", bus_b.stall_count); end
      checks++;
      if (bus_a.stall_count !== 16'(exp_a)) begin failures++; $display("FAIL wide_count got=%0d exp=%0d", bus_a.stall_count, exp_a); end
      idle();
      tick();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_md();
      test_imem_wait();
      test_md_reset();
      test_lu_md_same();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Control unit that sequences the pipelined PC register and the IF/ID and ID/EX pipeline registers.
- Decides each cycle whether the PC advances, which next-PC source is selected, and whether bubbles or flushes are injected.
- Handles load-use hazards, multi-cycle mul/div occupancy, instruction-memory wait states and control transfers.
- Sits between the ID-stage decoder and the PC/pipeline registers. Its `wpcir` output drives the PC register's hold input directly: 1 = hold, 0 = load npc.

Parameters:
- MD_LAT, 4, total mul/div latency in cycles (legal range 2..16); the pipe stalls for MD_LAT-1 cycles.
- DELAY_SLOT, 1, 1 = branch delay slot is executed (no IF/ID flush on taken transfer); 0 = flush IF/ID on taken transfer.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_rs  in  5  ID-stage source register rs.
- id_rt  in  5  ID-stage source register rt.
- id_use_rs  in  1  ID instruction reads rs.
- id_use_rt  in  1  ID instruction reads rt.
- id_pcsrc  in  2  ID transfer request: 0 = sequential, 1 = branch taken, 2 = jump register, 3 = jump.
- ex_wreg  in  1  EX instruction writes the register file.
- ex_m2reg  in  1  EX instruction is a load.
- ex_rd  in  5  EX destination register.
- ex_md_start  in  1  EX instruction starts a mul/div.
- imem_ready  in  1  instruction memory returns valid data this cycle.
- wpcir  out  1  1 = hold PC and IF/ID.
- pcsel  out  2  next-PC mux select for the PC input.
- ifid_flush  out  1  zero the IF/ID register at the next edge.
- idex_bubble  out  1  load a NOP into ID/EX at the next edge.
- md_busy  out  1  FSM is in S_MD.
- stall_count  out  CNT_W  saturating count of cycles with wpcir=1.

Behaviour:
- Reset is synchronous, sampled on the rising edge of `clock`. After the reset edge:
  - state = S_RUN, md counter = 0, stall_count = 0.
  - All combinational outputs reflect S_RUN with the current inputs.
  - While `reset` is high, wpcir=1 and pcsel=0.
- States:
  - S_RUN: normal operation.
  - S_MD: mul/div in progress.
- Hazard terms (combinational, S_RUN only):
  - lu = ex_m2reg & ex_wreg & (ex_rd≠0) & ((id_use_rs & id_rs==ex_rd) | (id_use_rt & id_rt==ex_rd)).
  - iw = ~imem_ready.
- Priority within a cycle: reset > S_MD > lu > iw > transfer.
- In S_MD:
  - wpcir=1, idex_bubble=1, pcsel=0, ifid_flush=0, md_busy=1.
  - If md counter==0, next state is S_RUN; otherwise the counter decrements.
  - ex_md_start is ignored in S_MD.
- In S_RUN:
  - If ex_md_start=1: next state is S_MD and the counter loads MD_LAT-2. The start cycle itself is not stalled unless lu or iw is set.
  - lu=1: wpcir=1, idex_bubble=1, pcsel=0, ifid_flush=0. This is exactly a one-cycle bubble; the next cycle re-evaluates.
  - else iw=1: wpcir=1, idex_bubble=0, pcsel=0, ifid_flush=0.
  - else: wpcir=0, pcsel=id_pcsrc, idex_bubble=0. ifid_flush=1 only when DELAY_SLOT==0 and id_pcsrc≠0.
- A transfer request that coincides with any stall is suppressed (pcsel=0). It is re-presented by ID on the unstall cycle, because IF/ID is held.
- stall_count:
  - Increments at each edge where wpcir=1 and reset=0.
  - Saturates at 2^CNT_W−1; no wrap.
- Reset asserted while in S_MD: return to S_RUN immediately at that edge. No residual stall.
- ex_md_start and lu in the same S_RUN cycle: the lu bubble is applied this cycle and the FSM still enters S_MD.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - PCSEL_SEQ/BR/JR/J constants (0..3).
  - State encoding S_RUN=1'b0, S_MD=1'b1.
  - REG_ZERO=5'd0.
- One natural sub-module: pipe_stall_counter, the saturating CNT_W-bit counter with synchronous reset and an enable input.
- Hazard compare logic and the FSM stay in the top module.

Test Plan:
- Reset high for 2 cycles, then low with imem_ready=1, id_pcsrc=0 → state S_RUN, wpcir=0, pcsel=0, stall_count=0.
- ex_m2reg=1, ex_wreg=1, ex_rd=5, id_use_rt=1, id_rt=5 for one cycle → that cycle wpcir=1, idex_bubble=1, stall_count increments by 1. Repeat the stimulus with ex_rd=0 → no stall.
- ex_md_start pulse with MD_LAT=4 → md_busy=1 and wpcir=1 for exactly 3 cycles, then S_RUN; stall_count=3.
- imem_ready=0 for 2 cycles while id_pcsrc=3 → wpcir=1, pcsel=0, idex_bubble=0 for both cycles; third cycle pcsel=3, wpcir=0. With DELAY_SLOT=0, ifid_flush=1 in that third cycle only.
- Reset asserted in the 2nd cycle of S_MD → next cycle md_busy=0, wpcir=0, stall_count=0.
- Force the counter to 16'hFFFE, then hold imem_ready=0 for 5 cycles → stall_count saturates at 16'hFFFF.
